pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups, one group per pipeline stage, with the inter-group carry registered between stages. Accepts one operation per cycle under a valid/ready handshake and sits between operand-fetch logic and any downstream consumer that can stall, such as an accumulator or ALU writeback.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_group.sv | 52 +++++
 rtl/pipelined_cla_adder.sv | 169 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg: stage-count and parameter-legality helpers for pipelined_cla_adder.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cla_pkg;

  function automatic bit cla_legal(input int width, input int group);
    return (width >= 1) && (group >= 1) && ((width % group) == 0);
  endfunction

  // Clamped to 1 so an illegal configuration still elaborates far enough to report itself.
  function automatic int cla_ngrp(input int width, input int group);
    if (group < 1 || width < group) begin
      return 1;
    end
    return width / group;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group: GROUP-bit combinational carry-lookahead slice.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products over generate/propagate terms, not a ripple chain.
  always_comb begin
    logic run_p;
    logic carry;
    run_p = 1'b1;
    carry = 1'b0;
    c     = '0;
    c[0]  = ci;
    for (int i = 0; i < GROUP; i++) begin
      run_p = 1'b1;
      carry = 1'b0;
      for (int j = i; j >= 0; j--) begin
        carry = carry | (g[j] & run_p);
        run_p = run_p & p[j];
      end
      c[i+1] = carry | (run_p & ci);
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign co    = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder: one lookahead group per pipeline stage, valid/ready flow.
// Define CLA_OVF_EN to add the registered signed-overflow output OVF.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef CLA_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int NGRP = cla_ngrp(WIDTH, GROUP);

  if (!cla_legal(WIDTH, GROUP)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
  end

  logic adv;

  // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
  assign adv      = ~OUT_VALID | OUT_READY;
  assign IN_READY = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int LO  = k * GROUP;
    localparam int HI  = LO + GROUP;
    localparam int REM = WIDTH - LO;

    logic             v_in;
    logic             c_in;
    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic [HI-1:0]    sum_in;
    logic [GROUP-1:0] s_grp;
    logic             co_grp;
    logic             cmsb_grp;
    logic             valid_d, valid_q;
    logic             co_d, co_q;
    logic [HI-1:0]    sum_d, sum_q;

    cla_group #(.GROUP(GROUP)) u_group (
      .a     (a_in[GROUP-1:0]),
      .b     (b_in[GROUP-1:0]),
      .ci    (c_in),
      .s     (s_grp),
      .co    (co_grp),
      .c_msb (cmsb_grp)
    );

    if (k == 0) begin : g_head
      assign v_in   = IN_VALID;
      assign c_in   = CIN ^ SUB;
      assign a_in   = A;
      assign b_in   = B ^ {WIDTH{SUB}};
      assign sum_in = s_grp;
    end else begin : g_body
      assign v_in   = g_stage[k-1].valid_q;
      assign c_in   = g_stage[k-1].co_q;
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign sum_in = {s_grp, g_stage[k-1].sum_q};
    end

    always_comb begin
      valid_d = valid_q;
      co_d    = co_q;
      sum_d   = sum_q;
      if (adv) begin
        valid_d = v_in;
        co_d    = co_grp;
        sum_d   = sum_in;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        valid_q <= 1'b0;
        co_q    <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        co_q    <= co_d;
        sum_q   <= sum_d;
      end
    end

    // Operand bits not yet consumed travel with the partial result.
    if (k < NGRP - 1) begin : g_ops
      localparam int NXT = REM - GROUP;
      logic [NXT-1:0] a_d, a_q;
      logic [NXT-1:0] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_in[REM-1:GROUP];
          b_d = b_in[REM-1:GROUP];
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef CLA_OVF_EN
    if (k == NGRP - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = cmsb_grp ^ co_grp;
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_no_ovf
      logic unused_cmsb;
      assign unused_cmsb = cmsb_grp;
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = cmsb_grp;
`endif
  end

  assign OUT_VALID = g_stage[NGRP-1].valid_q;
  assign SUM       = g_stage[NGRP-1].sum_q;
  assign COUT      = g_stage[NGRP-1].co_q;
`ifdef CLA_OVF_EN
  assign OVF       = g_stage[NGRP-1].g_ovf.ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder: directed and randomized checks for 16/4, 8/8 and 32/4.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic iv16, ir16, ov16, or16, cin16, sub16, co16;
  logic [15:0] a16, b16, s16;
  logic iv8, ir8, ov8, or8, cin8, sub8, co8;
  logic [7:0] a8, b8, s8;
  logic iv32, ir32, ov32, or32, cin32, sub32, co32;
  logic [31:0] a32, b32, s32;
`ifdef CLA_OVF_EN
  logic ovf16, ovf8, ovf32;
`endif

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(iv16), .IN_READY(ir16), .A(a16), .B(b16),
    .CIN(cin16), .SUB(sub16), .OUT_VALID(ov16), .OUT_READY(or16), .SUM(s16), .COUT(co16)
`ifdef CLA_OVF_EN
    , .OVF(ovf16)
`endif
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
    .CIN(cin8), .SUB(sub8), .OUT_VALID(ov8), .OUT_READY(or8), .SUM(s8), .COUT(co8)
`ifdef CLA_OVF_EN
    , .OVF(ovf8)
`endif
  );

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u_dut32 (
    .CLK(clk), .RST(rst), .IN_VALID(iv32), .IN_READY(ir32), .A(a32), .B(b32),
    .CIN(cin32), .SUB(sub32), .OUT_VALID(ov32), .OUT_READY(or32), .SUM(s32), .COUT(co32)
`ifdef CLA_OVF_EN
    , .OVF(ovf32)
`endif
  );

  // Reference: {ovf, cout, sum} of A + (SUB ? ~B : B) + (SUB ? ~CIN : CIN), plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint unsigned mask, av, bv, tot;
    logic [31:0] s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, b} & mask;
    if (sub) bv = ~bv & mask;
    tot  = av + bv + ((cin ^ sub) ? 64'd1 : 64'd0);
    s    = 32'(tot & mask);
    co   = tot[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
    checks++; if (s16 !== 16'h0 || co16 !== 1'b0) begin failures++; $display("FAIL reset_sum: got sum=%h cout=%b expected 0000/0", s16, co16); end
    checks++; if (ir16 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", ir16); end
    checks++; if (ov8 !== 1'b0 || ov32 !== 1'b0) begin failures++; $display("FAIL reset_sweep_valid: got %b/%b expected 0/0", ov8, ov32); end
`ifdef CLA_OVF_EN
    checks++; if (ovf16 !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf16); end
`endif
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin failures++; $display("FAIL post_reset: got valid=%b ready=%b expected 0/1", ov16, ir16); end
  endtask

  task automatic test_wrap();
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
    cyc();
    iv16 = 1'b0;
    for (int n = 0; n <= 3; n++) begin
      checks++;
      if (ov16 !== (n == 3)) begin failures++; $display("FAIL wrap_latency: edge+%0d got valid=%b expected %b", n, ov16, (n == 3)); end
      if (n < 3) cyc();
    end
    checks++; if (s16 !== 16'h0000 || co16 !== 1'b1) begin failures++; $display("FAIL wrap_result: got sum=%h cout=%b expected 0000/1", s16, co16); end
    cyc();
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL wrap_drain: got valid=%b expected 0", ov16); end
  endtask

  task automatic test_sub();
    for (int ci = 0; ci < 2; ci++) begin
      a16 = 16'h0005; b16 = 16'h0007; cin16 = ci[0]; sub16 = 1'b1; iv16 = 1'b1; or16 = 1'b1;
      cyc();
      iv16 = 1'b0;
      cyc(); cyc(); cyc();
      checks++;
      if (ov16 !== 1'b1 || s16 !== (ci == 1 ? 16'hFFFD : 16'hFFFE) || co16 !== 1'b0) begin
        failures++;
        $display("FAIL sub_borrow cin=%0d: got valid=%b sum=%h cout=%b expected 1/%h/0", ci, ov16, s16, co16, (ci == 1 ? 16'hFFFD : 16'hFFFE));
      end
      cyc();
    end
  endtask

  task automatic test_ovf();
`ifdef CLA_OVF_EN
    logic [15:0] ta [2];
    logic [15:0] ts [2];
    logic        tsub [2];
    ta[0] = 16'h7FFF; tsub[0] = 1'b0; ts[0] = 16'h8000;
    ta[1] = 16'h8000; tsub[1] = 1'b1; ts[1] = 16'h7FFF;
    for (int i = 0; i < 2; i++) begin
      a16 = ta[i]; b16 = 16'h0001; cin16 = 1'b0; sub16 = tsub[i]; iv16 = 1'b1; or16 = 1'b1;
      cyc();
      iv16 = 1'b0;
      cyc(); cyc(); cyc();
      checks++;
      if (ov16 !== 1'b1 || s16 !== ts[i] || ovf16 !== 1'b1) begin
        failures++;
        $display("FAIL ovf_case%0d: got valid=%b sum=%h ovf=%b expected 1/%h/1", i, ov16, s16, ovf16, ts[i]);
      end
      cyc();
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] exp;
    logic [15:0] ops_a [8];
    logic [15:0] ops_b [8];
    logic [1:0]  ops_c [8];
    logic [15:0] hold_s;
    int sent = 0;
    int got  = 0;
    hold_s = '0;
    for (int i = 0; i < 8; i++) begin
      ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom); ops_c[i] = 2'($urandom);
    end
    for (int c = 0; c < 60 && got < 8; c++) begin
      iv16  = (sent < 8);
      a16   = ops_a[sent % 8]; b16 = ops_b[sent % 8];
      cin16 = ops_c[sent % 8][0]; sub16 = ops_c[sent % 8][1];
      or16  = !(c >= 5 && c <= 7);
      #1;
      checks++;
      if (ir16 !== (!ov16 || or16)) begin failures++; $display("FAIL stream_in_ready c=%0d: got %b expected %b", c, ir16, (!ov16 || or16)); end
      if (!or16) begin
        if (c == 5) hold_s = s16;
        checks++;
        if (ov16 !== 1'b1 || s16 !== hold_s) begin failures++; $display("FAIL stall_hold c=%0d: got valid=%b sum=%h expected 1/%h", c, ov16, s16, hold_s); end
      end
      if (iv16 && ir16) begin
        q.push_back(model(16, 32'(a16), 32'(b16), cin16, sub16));
        sent++;
      end
      if (ov16 && or16) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stream_extra: got unexpected result %h expected none", s16);
        end else begin
          exp = q.pop_front();
          if (s16 !== exp[15:0] || co16 !== exp[32]) begin
            failures++; $display("FAIL stream_result #%0d: got %h/%b expected %h/%b", got, s16, co16, exp[15:0], exp[32]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    iv16 = 1'b0; or16 = 1'b1;
    checks++; if (got != 8 || q.size() != 0) begin failures++; $display("FAIL stream_count: got %0d results expected 8", got); end
    cyc();
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL stream_dup: got valid=%b expected 0", ov16); end
  endtask

  task automatic test_reset_midflight();
    or16 = 1'b1; cin16 = 1'b0; sub16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1'b1;
      cyc();
    end
    iv16 = 1'b0;
    checks++; if (ov16 !== 1'b0) begin failures++; $display("FAIL midflight_pre: got valid=%b expected 0", ov16); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (ov16 !== 1'b0) begin failures++; $display("FAIL midflight_discard n=%0d: got valid=%b expected 0", n, ov16); end
      cyc();
    end
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b1; iv16 = 1'b1;
    cyc();
    iv16 = 1'b0;
    for (int n = 0; n <= 3; n++) begin
      checks++;
      if (ov16 !== (n == 3)) begin failures++; $display("FAIL midflight_latency: edge+%0d got valid=%b expected %b", n, ov16, (n == 3)); end
      if (n < 3) cyc();
    end
    checks++; if (s16 !== 16'h2346 || co16 !== 1'b0) begin failures++; $display("FAIL midflight_result: got %h/%b expected 2346/0", s16, co16); end
    cyc();
  endtask

  task automatic test_sweep();
    logic [33:0] q8[$];
    logic [33:0] q32[$];
    logic [33:0] exp;
    int sent8 = 0, got8 = 0, sent32 = 0, got32 = 0;
    logic stall8, stall32;
    logic [7:0]  prev8;
    logic [31:0] prev32;
    // Latency of the two extreme configurations.
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; sub32 = 1'b0; iv32 = 1'b1; or32 = 1'b1;
    cyc();
    iv8 = 1'b0; iv32 = 1'b0;
    checks++; if (ov8 !== 1'b1 || s8 !== 8'h80 || co8 !== 1'b0) begin failures++; $display("FAIL lat8: got %b/%h/%b expected 1/80/0", ov8, s8, co8); end
    for (int n = 0; n <= 7; n++) begin
      checks++;
      if (ov32 !== (n == 7)) begin failures++; $display("FAIL lat32: edge+%0d got valid=%b expected %b", n, ov32, (n == 7)); end
      if (n < 7) cyc();
    end
    checks++; if (s32 !== 32'h0 || co32 !== 1'b1) begin failures++; $display("FAIL lat32_result: got %h/%b expected 00000000/1", s32, co32); end
    cyc();
    stall8 = 1'b0; stall32 = 1'b0; prev8 = '0; prev32 = '0;
    for (int c = 0; c < 10000 && (got8 < 1000 || got32 < 1000); c++) begin
      if (stall8) begin
        checks++;
        if (ov8 !== 1'b1 || s8 !== prev8) begin failures++; $display("FAIL sweep8_hold: got %b/%h expected 1/%h", ov8, s8, prev8); end
      end
      if (stall32) begin
        checks++;
        if (ov32 !== 1'b1 || s32 !== prev32) begin failures++; $display("FAIL sweep32_hold: got %b/%h expected 1/%h", ov32, s32, prev32); end
      end
      iv8  = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      or8  = ($urandom_range(0, 3) != 0);
      iv32 = (sent32 < 1000) && ($urandom_range(0, 3) != 0);
      a32  = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      or32 = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (ir8 !== (!ov8 || or8) || ir32 !== (!ov32 || or32)) begin
        failures++; $display("FAIL sweep_in_ready: got %b/%b expected %b/%b", ir8, ir32, (!ov8 || or8), (!ov32 || or32));
      end
      if (iv8 && ir8) begin q8.push_back(model(8, 32'(a8), 32'(b8), cin8, sub8)); sent8++; end
      if (iv32 && ir32) begin q32.push_back(model(32, a32, b32, cin32, sub32)); sent32++; end
      if (ov8 && or8) begin
        checks++;
        exp = (q8.size() != 0) ? q8.pop_front() : 34'h3_FFFF_FFFF;
        if (s8 !== exp[7:0] || co8 !== exp[32]
`ifdef CLA_OVF_EN
            || ovf8 !== exp[33]
`endif
           ) begin
          failures++; $display("FAIL sweep8_result #%0d: got %h/%b expected %h/%b", got8, s8, co8, exp[7:0], exp[32]);
        end
        got8++;
      end
      if (ov32 && or32) begin
        checks++;
        exp = (q32.size() != 0) ? q32.pop_front() : 34'h3_FFFF_FFFF;
        if (s32 !== exp[31:0] || co32 !== exp[32]
`ifdef CLA_OVF_EN
            || ovf32 !== exp[33]
`endif
           ) begin
          failures++; $display("FAIL sweep32_result #%0d: got %h/%b expected %h/%b", got32, s32, co32, exp[31:0], exp[32]);
        end
        got32++;
      end
      stall8 = ov8 && !or8;   prev8  = s8;
      stall32 = ov32 && !or32; prev32 = s32;
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
    checks++;
    if (got8 != 1000 || got32 != 1000 || q8.size() != 0 || q32.size() != 0) begin
      failures++; $display("FAIL sweep_count: got %0d/%0d results expected 1000/1000", got8, got32);
    end
  endtask

  initial begin
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    iv8  = 1'b0; or8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    test_reset();
    test_wrap();
    test_sub();
    test_ovf();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
